// File: rtl/cluster_bus_throttle_pkg.sv
// Shared types for the cluster bus port throttle: FSM states, counter sizing and default AXI structs.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cluster_bus_throttle_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ISOLATED = 2'd2
    } state_e;

    // Bits needed to hold a count from 0 up to and including max.
    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axi_b_t  b;
        logic    b_valid;
        logic    ar_ready;
        axi_r_t  r;
        logic    r_valid;
    } axi_resp_t;

endpackage

// File: rtl/cluster_bus_txn_counter.sv
// Outstanding-transaction counter, 0..Max, with an at-limit flag for admission control.
// Latency: count updates one cycle after the inc/dec strobe.
// Backpressure: none; the caller must never push it past Max or below 0.
module cluster_bus_txn_counter
    import cluster_bus_throttle_pkg::*;
#(
    parameter int unsigned Max = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          inc_i,
    input  logic                          dec_i,
    output logic [cnt_width(int'(Max))-1:0] cnt_o,
    output logic                          at_max_o
);

    localparam int CntW = cnt_width(int'(Max));

    logic [CntW-1:0] cnt_q, cnt_d;

    // Simultaneous inc and dec cancel; otherwise step by one.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Count register, cleared immediately by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_max_o = (cnt_q == CntW'(Max));

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(dec_i && (cnt_q == '0)));
    a_no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i) !(inc_i && at_max_o));

endmodule

// File: rtl/cluster_bus_port_throttle.sv
// Caps outstanding AXI reads/writes on one crossbar slave port and drains/isolates it on request.
// Latency: 0 cycles on every channel (combinational valid/ready gating, no cut registers).
// Backpressure: AW/AR held off at the limit or outside RUN (never after presentation); W blocked when isolated.
module cluster_bus_port_throttle
    import cluster_bus_throttle_pkg::*;
#(
    parameter int unsigned MaxRdTxns = 8,
    parameter int unsigned MaxWrTxns = 8,
    parameter type req_t  = axi_req_t,
    parameter type resp_t = axi_resp_t
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  req_t                                slv_req_i,
    output resp_t                               slv_resp_o,
    output req_t                                mst_req_o,
    input  resp_t                               mst_resp_i,
    input  logic                                isolate_i,
    output logic                                isolated_o,
    output logic [cnt_width(int'(MaxRdTxns))-1:0] rd_outstanding_o,
    output logic [cnt_width(int'(MaxWrTxns))-1:0] wr_outstanding_o
);

    state_e state_q, state_d;
    logic   aw_pending_q, aw_pending_d;
    logic   ar_pending_q, ar_pending_d;

    logic [cnt_width(int'(MaxRdTxns))-1:0] rd_cnt;
    logic [cnt_width(int'(MaxWrTxns))-1:0] wr_cnt;
    logic rd_at_max, wr_at_max;

    // Admission looks only at registered state, so a same-cycle B/R never opens AW/AR.
    // A request already shown to the crossbar keeps its slot open until it is taken.
    logic aw_open, ar_open, w_open;
    assign aw_open = ((state_q == ST_RUN) && !wr_at_max) || aw_pending_q;
    assign ar_open = ((state_q == ST_RUN) && !rd_at_max) || ar_pending_q;
    assign w_open  = (state_q != ST_ISOLATED);

    logic mst_aw_vld, mst_ar_vld, mst_b_rdy, mst_r_rdy;
    assign mst_aw_vld = slv_req_i.aw_valid && aw_open && !rst_i;
    assign mst_ar_vld = slv_req_i.ar_valid && ar_open && !rst_i;
    assign mst_b_rdy  = slv_req_i.b_ready && !rst_i;
    assign mst_r_rdy  = slv_req_i.r_ready && !rst_i;

    logic aw_hs, ar_hs, b_hs, r_last_hs;
    assign aw_hs     = mst_aw_vld && mst_resp_i.aw_ready;
    assign ar_hs     = mst_ar_vld && mst_resp_i.ar_ready;
    assign b_hs      = mst_resp_i.b_valid && mst_b_rdy;
    assign r_last_hs = mst_resp_i.r_valid && mst_r_rdy && mst_resp_i.r.last;

    // Pass-through of both directions with handshake signals gated; reset forces them low.
    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.aw_valid  = mst_aw_vld;
        mst_req_o.ar_valid  = mst_ar_vld;
        mst_req_o.w_valid   = slv_req_i.w_valid && w_open && !rst_i;
        mst_req_o.b_ready   = mst_b_rdy;
        mst_req_o.r_ready   = mst_r_rdy;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && aw_open && !rst_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && ar_open && !rst_i;
        slv_resp_o.w_ready  = mst_resp_i.w_ready && w_open && !rst_i;
        slv_resp_o.b_valid  = mst_resp_i.b_valid && !rst_i;
        slv_resp_o.r_valid  = mst_resp_i.r_valid && !rst_i;
    end

    // Next state and pending flags: drain completes only with nothing in flight or on the wire.
    always_comb begin
        state_d      = state_q;
        aw_pending_d = mst_aw_vld && !mst_resp_i.aw_ready;
        ar_pending_d = mst_ar_vld && !mst_resp_i.ar_ready;
        case (state_q)
            ST_RUN: begin
                if (isolate_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!isolate_i) begin
                    state_d = ST_RUN;
                end else if ((rd_cnt == '0) && (wr_cnt == '0) && !aw_pending_q && !ar_pending_q) begin
                    state_d = ST_ISOLATED;
                end
            end
            ST_ISOLATED: begin
                if (!isolate_i) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and pending-flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            aw_pending_q <= 1'b0;
            ar_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            aw_pending_q <= aw_pending_d;
            ar_pending_q <= ar_pending_d;
        end
    end

    cluster_bus_txn_counter #(.Max(MaxWrTxns)) u_wr_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (aw_hs),
        .dec_i    (b_hs),
        .cnt_o    (wr_cnt),
        .at_max_o (wr_at_max)
    );

    cluster_bus_txn_counter #(.Max(MaxRdTxns)) u_rd_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (ar_hs),
        .dec_i    (r_last_hs),
        .cnt_o    (rd_cnt),
        .at_max_o (rd_at_max)
    );

    assign isolated_o       = (state_q == ST_ISOLATED);
    assign rd_outstanding_o = rd_cnt;
    assign wr_outstanding_o = wr_cnt;

endmodule

// File: tb/tb_cluster_bus_port_throttle.sv
module tb_cluster_bus_port_throttle;
    import cluster_bus_throttle_pkg::*;

    localparam int MAX_RD = 1;
    localparam int MAX_WR = 2;

    logic      clk_i = 1'b0;
    logic      rst_i;
    axi_req_t  slv_req, mst_req;
    axi_resp_t slv_resp, mst_resp;
    logic      isolate, isolated;
    logic [0:0] rd_out;
    logic [1:0] wr_out;

    always #5 clk_i = ~clk_i;

    cluster_bus_port_throttle #(
        .MaxRdTxns (MAX_RD),
        .MaxWrTxns (MAX_WR)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .slv_req_i        (slv_req),
        .slv_resp_o       (slv_resp),
        .mst_req_o        (mst_req),
        .mst_resp_i       (mst_resp),
        .isolate_i        (isolate),
        .isolated_o       (isolated),
        .rd_outstanding_o (rd_out),
        .wr_outstanding_o (wr_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        slv_req  = '0;
        mst_resp = '0;
        slv_req.b_ready = 1'b1;
        slv_req.r_ready = 1'b1;
    endtask

    task automatic set_aw(input logic v, input logic r);
        slv_req.aw_valid  = v;
        mst_resp.aw_ready = r;
    endtask

    task automatic set_ar(input logic v, input logic r);
        slv_req.ar_valid  = v;
        mst_resp.ar_ready = r;
    endtask

    task automatic set_w(input logic v, input logic r);
        slv_req.w_valid  = v;
        mst_resp.w_ready = r;
    endtask

    task automatic set_r(input logic v, input logic last);
        mst_resp.r_valid = v;
        mst_resp.r.last  = last;
    endtask

    // Every handshake-related output packed together; all must be 0 under reset.
    function automatic logic [9:0] all_hs();
        return {mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid, mst_req.b_ready, mst_req.r_ready,
                slv_resp.aw_ready, slv_resp.ar_ready, slv_resp.w_ready, slv_resp.b_valid, slv_resp.r_valid};
    endfunction

    // Write-limit vectors: one row per cycle, inputs driven after the edge, outputs checked mid-cycle.
    typedef struct {
        logic awv;
        logic awr;
        logic bv;
        logic exp_mawv;
        logic exp_sawr;
        int   exp_wcnt;
    } vec_t;
    vec_t tbl[10];

    // Behavioural model of the port for the random phase (0 run, 1 drain, 2 isolated).
    int   m_mode, m_wc, m_rc;
    logic m_aw_shown, m_ar_shown;
    logic hold_aw, hold_ar;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        // Reset with every input handshake asserted: outputs must all stay low.
        rst_i   = 1'b1;
        isolate = 1'b0;
        idle();
        set_aw(1, 1); set_ar(1, 1); set_w(1, 1); set_r(1, 1);
        mst_resp.b_valid = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_handshakes", all_hs(), 0);
        chk("reset_wr_cnt", wr_out, 0);
        chk("reset_rd_cnt", rd_out, 0);
        chk("reset_isolated", isolated, 0);
        idle();
        rst_i = 1'b0;
        tick();

        // Write limit of 2 with B held off, then one B frees a slot for the next cycle.
        for (int i = 0; i < 10; i++) begin
            idle();
            set_aw(tbl[i].awv, tbl[i].awr);
            mst_resp.b_valid = tbl[i].bv;
            @(negedge clk_i);
            chk($sformatf("tbl%0d_mst_awv", i), mst_req.aw_valid, tbl[i].exp_mawv);
            chk($sformatf("tbl%0d_slv_awr", i), slv_resp.aw_ready, tbl[i].exp_sawr);
            chk($sformatf("tbl%0d_wcnt", i), wr_out, tbl[i].exp_wcnt);
            tick();
        end

        // Read limit of 1 over a 4-beat burst; next AR only after the last-beat cycle.
        idle(); set_ar(1, 1);
        @(negedge clk_i);
        chk("rd_first_ar", mst_req.ar_valid, 1);
        tick();
        for (int b = 0; b < 4; b++) begin
            idle(); set_ar(1, 1); set_r(1, b == 3);
            @(negedge clk_i);
            chk($sformatf("rd_beat%0d_cnt", b), rd_out, 1);
            chk($sformatf("rd_beat%0d_ar_blocked", b), mst_req.ar_valid, 0);
            tick();
        end
        idle(); set_ar(1, 1);
        @(negedge clk_i);
        chk("rd_after_last_cnt", rd_out, 0);
        chk("rd_after_last_ar", mst_req.ar_valid, 1);
        tick();
        idle(); set_r(1, 1);
        tick();
        idle();
        @(negedge clk_i);
        chk("rd_drained", rd_out, 0);
        tick();

        // AW already shown when isolate arrives: stays valid, isolation waits for its B.
        idle(); set_aw(1, 0);
        @(negedge clk_i); chk("pend_awv0", mst_req.aw_valid, 1);
        tick();
        isolate = 1'b1; set_aw(1, 0);
        @(negedge clk_i); chk("pend_awv1", mst_req.aw_valid, 1);
        tick();
        set_aw(1, 0);
        @(negedge clk_i); chk("pend_awv2", mst_req.aw_valid, 1);
        chk("pend_not_iso2", isolated, 0);
        tick();
        set_aw(1, 1);
        @(negedge clk_i); chk("pend_awv3", mst_req.aw_valid, 1);
        chk("pend_sawr3", slv_resp.aw_ready, 1);
        tick();
        idle();
        @(negedge clk_i); chk("pend_wcnt", wr_out, 1);
        chk("pend_not_iso4", isolated, 0);
        tick();
        mst_resp.b_valid = 1'b1;
        @(negedge clk_i); chk("pend_not_iso5", isolated, 0);
        tick();
        idle();
        @(negedge clk_i); chk("pend_not_iso6", isolated, 0);
        chk("pend_wcnt0", wr_out, 0);
        tick();
        @(negedge clk_i); chk("pend_iso7", isolated, 1);
        isolate = 1'b0;
        tick();
        @(negedge clk_i); chk("pend_run8", isolated, 0);
        tick();

        // Isolate from empty: one drain cycle, then isolated; everything blocked; resume.
        isolate = 1'b1;
        @(negedge clk_i); chk("empty_c0_iso", isolated, 0);
        tick();
        @(negedge clk_i); chk("empty_c1_iso", isolated, 0);
        tick();
        set_aw(1, 1); set_ar(1, 1); set_w(1, 1);
        @(negedge clk_i); chk("empty_c2_iso", isolated, 1);
        chk("empty_blocked", {mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid}, 0);
        chk("empty_rdy_blocked", {slv_resp.aw_ready, slv_resp.ar_ready, slv_resp.w_ready}, 0);
        tick();
        isolate = 1'b0; set_aw(1, 0); set_ar(1, 0); set_w(1, 0);
        @(negedge clk_i); chk("empty_c3_iso", isolated, 1);
        chk("empty_c3_blocked", {mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid}, 0);
        tick();
        @(negedge clk_i); chk("empty_c4_run", isolated, 0);
        chk("empty_resume", {mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid}, 3'b111);
        tick();
        set_aw(1, 1); set_ar(1, 1); set_w(1, 1);
        @(negedge clk_i); chk("empty_resume_rdy", {slv_resp.aw_ready, slv_resp.ar_ready, slv_resp.w_ready}, 3'b111);
        tick();
        idle(); mst_resp.b_valid = 1'b1; set_r(1, 1);
        @(negedge clk_i); chk("empty_cnts", {wr_out, rd_out}, {2'd1, 1'b1});
        tick();
        idle();
        @(negedge clk_i); chk("empty_cnts0", {wr_out, rd_out}, 0);
        tick();

        // Short isolate pulse with three transactions in flight (2 writes, 1 read): back to RUN.
        set_aw(1, 1); set_ar(1, 1);
        tick();
        idle(); set_aw(1, 1);
        tick();
        idle(); isolate = 1'b1;
        @(negedge clk_i); chk("pulse_cnts", {wr_out, rd_out}, {2'd2, 1'b1});
        tick();
        @(negedge clk_i); chk("pulse_drain_iso", isolated, 0);
        tick();
        isolate = 1'b0;
        @(negedge clk_i); chk("pulse_drop_iso", isolated, 0);
        tick();
        mst_resp.b_valid = 1'b1; set_r(1, 1);
        @(negedge clk_i); chk("pulse_run_iso", isolated, 0);
        tick();
        idle(); mst_resp.b_valid = 1'b1;
        tick();
        idle(); set_aw(1, 1);
        @(negedge clk_i); chk("pulse_cnts0", {wr_out, rd_out}, 0);
        chk("pulse_aw_admitted", mst_req.aw_valid, 1);
        chk("pulse_never_iso", isolated, 0);
        tick();

        // Asynchronous reset mid-burst: outputs and counters clear between clock edges.
        idle(); set_aw(1, 0); set_w(1, 1); mst_resp.b_valid = 1'b1; set_r(1, 0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_handshakes", all_hs(), 0);
        chk("arst_cnts", {wr_out, rd_out}, 0);
        chk("arst_isolated", isolated, 0);
        idle();
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // Randomised traffic against the behavioural model.
        m_mode = 0; m_wc = 0; m_rc = 0;
        m_aw_shown = 1'b0; m_ar_shown = 1'b0;
        hold_aw = 1'b0; hold_ar = 1'b0;
        isolate = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic aw_ok, ar_ok, w_ok, drained, aw_hs, ar_hs, b_hs, rl_hs;
            logic [31:0] addr;
            idle();
            addr = $urandom;
            slv_req.aw.addr   = addr;
            slv_req.aw_valid  = hold_aw ? 1'b1 : 1'($urandom_range(0, 1));
            mst_resp.aw_ready = 1'($urandom_range(0, 1));
            slv_req.ar_valid  = hold_ar ? 1'b1 : 1'($urandom_range(0, 1));
            mst_resp.ar_ready = 1'($urandom_range(0, 1));
            set_w(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            mst_resp.b_valid  = (m_wc > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            slv_req.b_ready   = 1'($urandom_range(0, 1));
            mst_resp.r_valid  = (m_rc > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            mst_resp.r.last   = ($urandom_range(0, 2) == 0);
            slv_req.r_ready   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) isolate = ~isolate;

            // A request may go out if the port is running below its cap, or it is already on the wire.
            aw_ok = ((m_mode == 0) && (m_wc < MAX_WR)) || m_aw_shown;
            ar_ok = ((m_mode == 0) && (m_rc < MAX_RD)) || m_ar_shown;
            w_ok  = (m_mode != 2);

            @(negedge clk_i);
            chk($sformatf("rnd%0d_gates", cyc),
                {mst_req.aw_valid, slv_resp.aw_ready, mst_req.ar_valid, slv_resp.ar_ready,
                 mst_req.w_valid, slv_resp.w_ready, isolated},
                {slv_req.aw_valid & aw_ok, mst_resp.aw_ready & aw_ok,
                 slv_req.ar_valid & ar_ok, mst_resp.ar_ready & ar_ok,
                 slv_req.w_valid & w_ok, mst_resp.w_ready & w_ok, 1'(m_mode == 2)});
            chk($sformatf("rnd%0d_counts", cyc), {wr_out, rd_out}, {2'(m_wc), 1'(m_rc)});
            chk($sformatf("rnd%0d_aw_addr", cyc), mst_req.aw.addr, addr);

            aw_hs   = slv_req.aw_valid && aw_ok && mst_resp.aw_ready;
            ar_hs   = slv_req.ar_valid && ar_ok && mst_resp.ar_ready;
            b_hs    = mst_resp.b_valid && slv_req.b_ready;
            rl_hs   = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
            drained = (m_wc == 0) && (m_rc == 0) && !m_aw_shown && !m_ar_shown;
            m_wc = m_wc + int'(aw_hs) - int'(b_hs);
            m_rc = m_rc + int'(ar_hs) - int'(rl_hs);
            m_aw_shown = slv_req.aw_valid && aw_ok && !mst_resp.aw_ready;
            m_ar_shown = slv_req.ar_valid && ar_ok && !mst_resp.ar_ready;
            hold_aw = slv_req.aw_valid && !aw_hs;
            hold_ar = slv_req.ar_valid && !ar_hs;
            case (m_mode)
                0: if (isolate) m_mode = 1;
                1: if (!isolate) m_mode = 0; else if (drained) m_mode = 2;
                default: if (!isolate) m_mode = 0;
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
